lza_scan_counter: RTL and testbench

- Leading-zero anticipator and counter for the add/subtract datapath.
- Consumes the per-bit propagate (P) and generate (G) vectors produced by the adder bit-slice bank in the same cycle as the sum.
- Builds the LZA indicator string, then scans it MSB-first, CHUNK bits per cycle, to produce the normalization left-shift amount for the post-add shifter.
- Valid/ready on both sides, so it sits between the adder stage and the normalizer.

---
 rtl/fpu_lza_pkg.sv | 21 ++
 rtl/lza_indicator.sv | 42 ++++
 rtl/lza_scan_counter.sv | 167 ++++++++++++++++
 tb/tb_lza_scan_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_lza_pkg.sv
// Shared definitions for the leading-zero anticipator datapath.
//   state_t     : scan FSM states (IDLE, SCAN, DONE)
//   W_DEFAULT   : default operand/indicator width
//   CHUNK_DEFAULT: default indicator bits examined per scan cycle
//   calc_nch()  : number of CHUNK-wide slices needed to cover W bits
package fpu_lza_pkg;

   localparam int W_DEFAULT     = 26;
   localparam int CHUNK_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   function automatic int calc_nch(input int w, input int chunk);
      return (w + chunk - 1) / chunk;
   endfunction

endpackage

// File: rtl/lza_indicator.sv
// Combinational LZA indicator string generator.
// Turns per-bit propagate/generate into the f string whose highest set bit
// predicts the position of the leading significant bit of the sum.
// Ports:
//   P_i [W-1:0] : propagate vector, A[i]^B[i]
//   G_i [W-1:0] : generate vector,  A[i]&B[i]
//   f_o [W-1:0] : indicator string
module lza_indicator #(
   parameter int W = fpu_lza_pkg::W_DEFAULT
) (
   input  logic [W-1:0] P_i,
   input  logic [W-1:0] G_i,
   output logic [W-1:0] f_o
);

   // Extended vectors: bit 0 is position -1, bit W+1 is position W.
   // Both out-of-range positions read as T=0, G=0, K=1.
   logic [W+1:0] tx;
   logic [W+1:0] gx;
   logic [W+1:0] kx;

   assign tx = {1'b0, P_i, 1'b0};
   assign gx = {1'b0, G_i, 1'b0};
   assign kx = {1'b1, ~P_i & ~G_i, 1'b1};

   // Aligned views: *_hi = position i+1, *_mid = position i, *_lo = position i-1.
   logic [W-1:0] t_hi;
   logic [W-1:0] g_mid;
   logic [W-1:0] k_mid;
   logic [W-1:0] g_lo;
   logic [W-1:0] k_lo;

   assign t_hi  = tx[W+1:2];
   assign g_mid = gx[W:1];
   assign k_mid = kx[W:1];
   assign g_lo  = gx[W-1:0];
   assign k_lo  = kx[W-1:0];

   assign f_o = ( t_hi & ((g_mid & ~k_lo) | (k_mid & ~g_lo)))
              | (~t_hi & ((k_mid & ~k_lo) | (g_mid & ~g_lo)));

endmodule

// File: rtl/lza_scan_counter.sv
// Leading-zero anticipator and counter for the add/subtract datapath.
// Captures the LZA indicator string built from P/G, then scans it MSB-first,
// CHUNK bits per cycle, producing the normalization left-shift amount.
// Optional macro LZA_FIXED_LATENCY_EN: when defined, every scan visits all
// chunks so the result always appears a fixed number of cycles after accept.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   in_valid_i    : P/G vectors valid
//   in_ready_o    : block can accept P/G (IDLE only)
//   P_i, G_i      : propagate / generate vectors
//   out_valid_o   : result valid, held until out_ready_i
//   out_ready_i   : downstream accepts result
//   shift_o       : predicted leading-zero count (W when zero)
//   zero_o        : indicator string all zero
module lza_scan_counter
   import fpu_lza_pkg::*;
#(
   parameter int W     = W_DEFAULT,
   parameter int CHUNK = CHUNK_DEFAULT,
   parameter int CW    = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [W-1:0]  P_i,
   input  logic [W-1:0]  G_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [CW-1:0] shift_o,
   output logic          zero_o
);

   localparam int NCH = calc_nch(W, CHUNK);
   localparam int SW  = NCH * CHUNK;
   localparam int IW  = $clog2(NCH + 1);

   state_t        state_q, state_d;
   logic [SW-1:0] scan_q, scan_d;
   logic [CW-1:0] count_q, count_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          found_q, found_d;
   logic          zero_q, zero_d;

   logic [W-1:0]     f;
   logic [SW-1:0]    scan_load;
   logic [CHUNK-1:0] chunk;
   logic             hit;
   logic [CW-1:0]    lz;
   logic             last;

   lza_indicator #(.W(W)) u_indicator (
      .P_i (P_i),
      .G_i (G_i),
      .f_o (f)
   );

   // MSB-aligned, zero padding at the LSB end never produces a hit.
   assign scan_load = SW'(f) << (SW - W);
   assign chunk     = scan_q[SW-1 -: CHUNK];
   assign last      = (idx_q == IW'(NCH - 1));

   // Chunk priority encoder: leading zeros within the top CHUNK bits.
   always_comb begin
      hit = 1'b0;
      lz  = '0;
      for (int unsigned j = 0; j < CHUNK; j++) begin
         if (!hit && chunk[CHUNK-1-j]) begin
            hit = 1'b1;
            lz  = CW'(j);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         scan_q  <= '0;
         count_q <= '0;
         idx_q   <= '0;
         found_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         scan_q  <= scan_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         found_q <= found_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      scan_d  = scan_q;
      count_d = count_q;
      idx_d   = idx_q;
      found_d = found_q;
      zero_d  = zero_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               scan_d  = scan_load;
               count_d = '0;
               idx_d   = '0;
               found_d = 1'b0;
               zero_d  = 1'b0;
               state_d = SCAN;
            end
         end

         SCAN: begin
`ifdef LZA_FIXED_LATENCY_EN
            // Count freezes once the first one is seen; the walk continues
            // through every chunk so latency is independent of the data.
            if (!found_q) begin
               if (hit) begin
                  count_d = count_q + lz;
                  found_d = 1'b1;
               end else begin
                  count_d = count_q + CW'(CHUNK);
               end
            end
            scan_d = scan_q << CHUNK;
            idx_d  = idx_q + 1'b1;
            if (last) begin
               state_d = DONE;
               if (!found_q && !hit) begin
                  zero_d  = 1'b1;
                  count_d = CW'(W);
               end
            end
`else
            if (hit) begin
               count_d = count_q + lz;
               found_d = 1'b1;
               state_d = DONE;
            end else begin
               count_d = count_q + CW'(CHUNK);
               scan_d  = scan_q << CHUNK;
               idx_d   = idx_q + 1'b1;
               if (last) begin
                  state_d = DONE;
                  if (!found_q) begin
                     zero_d  = 1'b1;
                     count_d = CW'(W);
                  end
               end
            end
`endif
         end

         DONE: begin
            if (out_ready_i) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign shift_o     = count_q;
   assign zero_o      = zero_q;

endmodule

// File: tb/tb_lza_scan_counter.sv
// Directed self-checking bench for lza_scan_counter (W=26, CHUNK=4, NCH=7).
module tb_lza_scan_counter;

   localparam int W  = 26;
   localparam int CW = 5;

`ifdef LZA_FIXED_LATENCY_EN
   localparam int LAT_MSB = 7;
   localparam int LAT_MID = 7;
`else
   localparam int LAT_MSB = 1;
   localparam int LAT_MID = 4;
`endif
   localparam int LAT_ZERO = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  p;
   logic [W-1:0]  g;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] shift;
   logic          zero;

   int tests = 0;
   int fails = 0;

   // Case vectors
   logic [W-1:0] p_ones;
   logic [W-1:0] g_msb;
   logic [W-1:0] g_mid;

   always #5 clk = ~clk;

   lza_scan_counter #(.W(26), .CHUNK(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .P_i         (p),
      .G_i         (g),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .shift_o     (shift),
      .zero_o      (zero)
   );

   // Waits (bounded) for IDLE, then presents one P/G pair for a single accept edge.
   task automatic send(input logic [W-1:0] pv, input logic [W-1:0] gv);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready) begin
         tests++; fails++;
         $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
      end
      p = pv; g = gv; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Counts edges after accept until out_valid is seen (bounded at 50).
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; p = '0; g = '0;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      tests++; if (shift !== 5'd0) begin fails++; $display("FAIL reset_shift: got %0d want 0", shift); end
      tests++; if (zero !== 1'b0) begin fails++; $display("FAIL reset_zero: got %0b want 0", zero); end
      rst = 1'b0;
   endtask

   task automatic test_all_zero;
      int lat;
      send(p_ones, '0);
      wait_valid(lat);
      tests++; if (lat != LAT_ZERO) begin fails++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT_ZERO); end
      tests++; if (zero !== 1'b1) begin fails++; $display("FAIL zero_flag: got %0b want 1", zero); end
      tests++; if (shift !== 5'd26) begin fails++; $display("FAIL zero_shift: got %0d want 26", shift); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL zero_in_ready_done: got %0b want 0", in_ready); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL zero_handshake_valid: got %0b want 0", out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL zero_handshake_ready: got %0b want 1", in_ready); end
   endtask

   task automatic test_msb;
      int lat;
      send('0, g_msb);
      wait_valid(lat);
      tests++; if (lat != LAT_MSB) begin fails++; $display("FAIL msb_latency: got %0d want %0d", lat, LAT_MSB); end
      tests++; if (shift !== 5'd0) begin fails++; $display("FAIL msb_shift: got %0d want 0", shift); end
      tests++; if (zero !== 1'b0) begin fails++; $display("FAIL msb_zero: got %0b want 0", zero); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_mid;
      int lat;
      send('0, g_mid);
      wait_valid(lat);
      tests++; if (lat != LAT_MID) begin fails++; $display("FAIL mid_latency: got %0d want %0d", lat, LAT_MID); end
      tests++; if (shift !== 5'd14) begin fails++; $display("FAIL mid_shift: got %0d want 14", shift); end
      tests++; if (zero !== 1'b0) begin fails++; $display("FAIL mid_zero: got %0b want 0", zero); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      int lat;
      send('0, g_mid);
      wait_valid(lat);
      tests++; if (lat != LAT_MID) begin fails++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT_MID); end
      // Offer a different input during the stall; it must be ignored.
      p = '0; g = g_msb; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid[%0d]: got %0b want 1", i, out_valid); end
         tests++; if (shift !== 5'd14) begin fails++; $display("FAIL bp_hold_shift[%0d]: got %0d want 14", i, shift); end
         tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_ready[%0d]: got %0b want 0", i, in_ready); end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %0b want 0", out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
   endtask

   task automatic test_reset_mid;
      int lat;
      send(p_ones, '0);          // accept edge E0 just passed
      @(posedge clk);            // E1
      @(posedge clk); #1;        // E2
      rst = 1'b1;
      @(posedge clk); #1;        // E3 with reset
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_in_ready: got %0b want 1", in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid: got %0b want 0", out_valid); end
      tests++; if (shift !== 5'd0) begin fails++; $display("FAIL rstmid_shift: got %0d want 0", shift); end
      tests++; if (zero !== 1'b0) begin fails++; $display("FAIL rstmid_zero: got %0b want 0", zero); end
      rst = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_stale_valid: got %0b want 0", out_valid); end
      end
      send('0, g_msb);
      wait_valid(lat);
      tests++; if (lat != LAT_MSB) begin fails++; $display("FAIL rstmid_new_latency: got %0d want %0d", lat, LAT_MSB); end
      tests++; if (shift !== 5'd0) begin fails++; $display("FAIL rstmid_new_shift: got %0d want 0", shift); end
      tests++; if (zero !== 1'b0) begin fails++; $display("FAIL rstmid_new_zero: got %0b want 0", zero); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back;
      int lat;
      out_ready = 1'b1;
      send('0, g_msb);
      wait_valid(lat);
      tests++; if (lat != LAT_MSB) begin fails++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, LAT_MSB); end
      tests++; if (shift !== 5'd0) begin fails++; $display("FAIL b2b_first_shift: got %0d want 0", shift); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_overlap_ready: got %0b want 0", in_ready); end
      send('0, g_mid);
      wait_valid(lat);
      tests++; if (lat != LAT_MID) begin fails++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, LAT_MID); end
      tests++; if (shift !== 5'd14) begin fails++; $display("FAIL b2b_second_shift: got %0d want 14", shift); end
      tests++; if (zero !== 1'b0) begin fails++; $display("FAIL b2b_second_zero: got %0b want 0", zero); end
      @(posedge clk); #1;
      out_ready = 1'b0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_final_valid: got %0b want 0", out_valid); end
   endtask

   initial begin
      p_ones = '1;
      g_msb  = '0; g_msb[25] = 1'b1;
      g_mid  = '0; g_mid[10] = 1'b1;

      test_reset;
      test_all_zero;
      test_msb;
      test_mid;
      test_backpressure;
      test_reset_mid;
      test_back_to_back;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
